// File: rtl/life_pkg.sv
// Shared types and constants for the 8x8 Game of Life controller slice.
package life_pkg;

    localparam int GRID_W = 64;
    localparam int GRID_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } life_state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        EXTINCT = 2'd1,
        STABLE  = 2'd2,
        MAXGEN  = 2'd3
    } halt_reason_t;

endpackage

// File: rtl/datapath.sv
// Combinational 8x8 Life rule; cells beyond the border are treated as dead.
module datapath
    import life_pkg::*;
(
    input  logic [GRID_W-1:0] grid,
    output logic [GRID_W-1:0] grid_evolve
);

    always_comb begin
        grid_evolve = '0;
        for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N; c++) begin : g_cell
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) &&
                            (r + dr >= 0) && (r + dr < GRID_N) &&
                            (c + dc >= 0) && (c + dc < GRID_N)) begin
                            if (grid[(r + dr) * GRID_N + (c + dc)]) n++;
                        end
                    end
                end
                grid_evolve[r * GRID_N + c] = grid[r * GRID_N + c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
    end

endmodule

// File: rtl/life_tick_div.sv
// Free-running divider for RUN pacing: tick is high on the terminal count.
module life_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == LAST) cnt_q <= '0;
            else               cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/life_controller.sv
// Owns the generation register, sequences load/run/step/stop and halts on
// extinction, a still life or the generation limit.
module life_controller
    import life_pkg::*;
#(
    parameter int GEN_W      = 16,
    parameter int TICK_DIV   = 4,
    parameter bit EXT_EVOLVE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [GRID_W-1:0] load_grid,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic [GEN_W-1:0]  max_gen,
    input  logic [GRID_W-1:0] grid_evolve,
    output logic [GRID_W-1:0] grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic [1:0]        state,
    output logic              halted,
    output logic [1:0]        halt_reason
);

    life_state_t       state_q, state_d;
    halt_reason_t      reason_q, reason_d;
    logic [GRID_W-1:0] grid_q;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic [GEN_W:0]    gen_inc;
    logic              halted_q;
    logic              load_ready_q;
    logic [GRID_W-1:0] evolve;
    logic              tick;
    logic              load_acc;
    logic              commit;

    // The bench may feed its own next-state model in place of the datapath.
    if (EXT_EVOLVE) begin : g_ext
        assign evolve = grid_evolve;
    end else begin : g_dp
        datapath u_datapath (
            .grid        (grid_q),
            .grid_evolve (evolve)
        );
    end

    life_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == IDLE && start && !load_acc),
        .en    (state_q == RUN),
        .tick  (tick)
    );

    assign load_acc = load_valid && load_ready_q;
    assign commit   = (state_q == RUN && tick && !stop) || (state_q == STEP);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        gen_inc  = {1'b0, gen_q} + (GEN_W + 1)'(1);
        gen_d    = (&gen_q) ? gen_q : gen_inc[GEN_W-1:0];
        reason_d = NONE;
        if (evolve == '0)                                     reason_d = EXTINCT;
        else if (evolve == grid_q)                            reason_d = STABLE;
        else if (max_gen != '0 && gen_inc >= {1'b0, max_gen}) reason_d = MAXGEN;

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load_acc)   state_d = IDLE;
                else if (start) state_d = RUN;
                else if (step)  state_d = STEP;
            end
            RUN: begin
                if (stop)                            state_d = IDLE;
                else if (commit && reason_d != NONE) state_d = HALT;
            end
            STEP:    state_d = (reason_d != NONE) ? HALT : IDLE;
            HALT:    if (load_acc || stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grid_q       <= '0;
            gen_q        <= '0;
            halted_q     <= 1'b0;
            reason_q     <= NONE;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            load_ready_q <= (state_d == IDLE) || (state_d == HALT);
            if (load_acc) begin
                grid_q   <= load_grid;
                gen_q    <= '0;
                halted_q <= 1'b0;
                reason_q <= NONE;
            end else if (commit) begin
                grid_q <= evolve;
                gen_q  <= gen_d;
                if (reason_d != NONE) begin
                    halted_q <= 1'b1;
                    reason_q <= reason_d;
                end
            end else if (state_q == HALT && stop) begin
                halted_q <= 1'b0;
                reason_q <= NONE;
            end
        end
    end

    assign load_ready  = load_ready_q;
    assign grid        = grid_q;
    assign gen_count   = gen_q;
    assign state       = state_q;
    assign halted      = halted_q;
    assign halt_reason = reason_q;

endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller; a local Life model stands in for the datapath.
module tb_life_controller;
    import life_pkg::*;

    localparam int GEN_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic              load_ready;
    logic [63:0]       load_grid;
    logic              start;
    logic              stop;
    logic              step;
    logic [GEN_W-1:0]  max_gen;
    logic [63:0]       grid_evolve;
    logic [63:0]       grid;
    logic [GEN_W-1:0]  gen_count;
    logic [1:0]        state;
    logic              halted;
    logic [1:0]        halt_reason;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_0000_0E00;
    localparam logic [63:0] BLINK_V = 64'h0000_0000_0004_0404;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;

    life_controller #(.GEN_W(GEN_W), .TICK_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_grid   (load_grid),
        .start       (start),
        .stop        (stop),
        .step        (step),
        .max_gen     (max_gen),
        .grid_evolve (grid_evolve),
        .grid        (grid),
        .gen_count   (gen_count),
        .state       (state),
        .halted      (halted),
        .halt_reason (halt_reason)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] life_model(input logic [63:0] g);
        logic [63:0] nx;
        nx = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8 && g[(r + dr) * 8 + c + dc])
                            n++;
                nx[r * 8 + c] = g[r * 8 + c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return nx;
    endfunction

    always_comb grid_evolve = life_model(grid);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [63:0] g);
        load_valid = 1'b1;
        load_grid  = g;
        cyc(1);
        load_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_grid = '0;
        start = 1'b0; stop = 1'b0; step = 1'b0; max_gen = '0;
        cyc(2);
        check("rst_state",  state,       IDLE);
        check("rst_grid",   grid,        64'h0);
        check("rst_gen",    gen_count,   0);
        check("rst_halted", halted,      0);
        check("rst_reason", halt_reason, NONE);
        check("rst_ready",  load_ready,  1);
        reset = 1'b0;
        cyc(1);

        // Blinker, single step
        do_load(BLINK_H);
        check("t1_load_grid", grid, BLINK_H);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        check("t1_in_step", state, STEP);
        check("t1_ready_lo", load_ready, 0);
        cyc(1);
        check("t1_grid",   grid,      BLINK_V);
        check("t1_gen",    gen_count, 1);
        check("t1_state",  state,     IDLE);
        check("t1_halted", halted,    0);

        // Blinker, generation limit
        max_gen = 5;
        do_load(BLINK_H);
        check("t2_gen_clr", gen_count, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("t2_run", state, RUN);
        cyc(3);
        check("t2_no_early", grid, BLINK_H);
        cyc(1);
        check("t2_c1_grid", grid,      BLINK_V);
        check("t2_c1_gen",  gen_count, 1);
        cyc(4);
        check("t2_c2_grid", grid, BLINK_H);
        cyc(12);
        check("t2_state",  state,       HALT);
        check("t2_reason", halt_reason, MAXGEN);
        check("t2_halted", halted,      1);
        check("t2_gen",    gen_count,   5);
        check("t2_grid",   grid,        BLINK_V);
        check("t2_ready",  load_ready,  1);
        start = 1'b1; step = 1'b1;
        cyc(2);
        start = 1'b0; step = 1'b0;
        check("t2_ign_state", state, HALT);
        check("t2_ign_grid",  grid,  BLINK_V);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("t2_stop_state",  state,       IDLE);
        check("t2_stop_halted", halted,      0);
        check("t2_stop_reason", halt_reason, NONE);
        check("t2_stop_gen",    gen_count,   5);
        max_gen = '0;

        // Still life
        do_load(BLOCK);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        check("t3_state",  state,       HALT);
        check("t3_reason", halt_reason, STABLE);
        check("t3_gen",    gen_count,   1);
        check("t3_grid",   grid,        BLOCK);

        // Extinction, loaded straight out of HALT
        do_load(64'h1);
        check("t4_load_state",  state,       IDLE);
        check("t4_load_halted", halted,      0);
        check("t4_load_reason", halt_reason, NONE);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(1);
        check("t4_grid",   grid,        64'h0);
        check("t4_state",  state,       HALT);
        check("t4_reason", halt_reason, EXTINCT);
        check("t4_gen",    gen_count,   1);

        // Stop coinciding with a commit; loads offered during RUN are refused
        do_load(BLINK_H);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        load_valid = 1'b1; load_grid = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc(4);
        load_valid = 1'b0;
        check("t5_run_grid", grid,      BLINK_V);
        check("t5_run_gen",  gen_count, 1);
        cyc(3);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("t5_state", state,      IDLE);
        check("t5_grid",  grid,       BLINK_V);
        check("t5_gen",   gen_count,  1);
        check("t5_ready", load_ready, 1);
        cyc(5);
        check("t5_hold_grid", grid, BLINK_V);

        // Reset mid-run, then simultaneous requests
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        check("t6_run", state, RUN);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_state",  state,      IDLE);
        check("t6_rst_grid",   grid,       64'h0);
        check("t6_rst_gen",    gen_count,  0);
        check("t6_rst_halted", halted,     0);
        check("t6_rst_ready",  load_ready, 1);
        #1 reset = 1'b0;
        cyc(1);
        load_valid = 1'b1; load_grid = BLINK_H; start = 1'b1; step = 1'b1;
        cyc(1);
        load_valid = 1'b0; start = 1'b0; step = 1'b0;
        check("t6_load_state", state, IDLE);
        check("t6_load_grid",  grid,  BLINK_H);
        cyc(5);
        check("t6_drop_state", state,     IDLE);
        check("t6_drop_grid",  grid,      BLINK_H);
        check("t6_drop_gen",   gen_count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
